q_sys_descriptor_mem_arbiter: RTL and testbench
===============================================

# q_sys_descriptor_mem_arbiter

Two-requester Avalon-MM arbiter that shares the single-port 2048×32 descriptor memory between a CPU data master (port A) and a DMA descriptor engine (port B). Sits between the two masters and the memory's single port, issues at most one access per cycle, and returns read data to the winning requester one cycle after acceptance. Arbitration is round-robin by default, with a fixed-priority option; a freeze input halts new grants without dropping in-flight reads.

## Interface
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (A wins all ties)

- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- freeze  in  1  when high, no new grants; in-flight read still returns
- a_read, b_read  in  1  read request
- a_write, b_write  in  1  write request
- a_address, b_address  in  ADDR_W  word address
- a_byteenable, b_byteenable  in  BE_W  byte lanes (writes only)
- a_writedata, b_writedata  in  DATA_W  write data
- a_waitrequest, b_waitrequest  out  1  request not accepted this cycle
- a_readdata, b_readdata  out  DATA_W  read data
- a_readdatavalid, b_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  BE_W  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  memory clock enable; constant 1
- mem_readdata  in  DATA_W  from memory, valid one cycle after a read is issued

## Operation
- req_x = x_read | x_write. If a master asserts both read and write, it is treated as a write.
- Grant is combinational each cycle, from req_a, req_b, freeze, reset and last_grant:
  - reset or freeze: no grant.
  - Exactly one requester: that one is granted.
  - Both requesting: round-robin grants the port that is not last_grant; PRIORITY_MODE=1 grants A.
- Granted port: waitrequest=0 and its address, byteenable, writedata and write are muxed to mem_*; mem_chipselect=1.
- Non-granted port: waitrequest=1. A requester must hold its request stable until accepted.
- Idle (no grant): mem_chipselect=0, mem_write=0; mem_address and mem_writedata hold their last values (don't-care).
- Reads drive mem_byteenable=all ones, regardless of the requester's byteenable.
- last_grant register: updates on every grant; in PRIORITY_MODE=1 it is unused.
- Read return pipeline: one register stage.
  - rd_pend (1 bit) and rd_port record each granted read.
  - The next cycle, mem_readdata goes to both x_readdata buses; only rd_port's readdatavalid is high.
  - Writes produce no readdatavalid.
- Throughput: one access per cycle. Back-to-back reads, including alternating A/B, return in issue order.
- freeze rising while a read is pending: that read's readdatavalid still fires the next cycle.
- Reset mid-operation: the pending read is discarded and no readdatavalid follows.

## Timing
- Reset values: a/b_waitrequest=1 (held high while reset is asserted); a/b_readdatavalid=0; a/b_readdata=0; mem_chipselect=0; mem_write=0; mem_address=0; last_grant=B, so A wins the first tie.
- Accept cycle T is the cycle with waitrequest=0 and a request present.
  - Write: lands in memory at the clk edge ending T.
  - Read: readdatavalid is high in T+1 only.
- Accept-to-readdatavalid latency is fixed at 1 cycle; there is no stall path on the return side.
- Waitrequest is combinational from requests. There is no combinational path from mem_readdata to any waitrequest.
- Worst-case wait under round-robin with both ports continuously requesting: 1 cycle.

## Structure
- Shared package q_sys_descriptor_mem_pkg holds:
  - constants ADDR_W, DATA_W, BE_W, MEM_DEPTH=2048;
  - enum port_t {PORT_A, PORT_B};
  - PRIORITY_MODE encodings.
- Sub-module q_sys_rr_arbiter2: 2-input arbiter with the last_grant register.
  - Inputs: req[1:0], freeze, mode.
  - Output: one-hot grant[1:0].
- The top level contains the request mux, the read-return register stage and the readdata fan-out.

## Test plan
- After reset, A and B both read (A addr 0x010, B addr 0x7FF) and hold -> A accepted in cycle 0, B in cycle 1; A readdatavalid in cycle 1, B in cycle 2, each carrying its preloaded word.
- A writes 0xDEADBEEF to 0x123 with byteenable 0b0011, then reads 0x123 -> read returns old[31:16] concatenated with 0xBEEF.
- Both ports stream continuous reads for 20 cycles -> grants alternate A,B,A,B; 20 readdatavalids with no gaps; neither waitrequest stays high more than 1 cycle.
- PRIORITY_MODE=1 with both ports continuously requesting for 10 cycles -> A accepted every cycle, b_waitrequest=1 throughout; B accepted the first cycle A drops its request.
- B read accepted at T, freeze raised at T+1 for 5 cycles -> b_readdatavalid fires at T+1; no accepts during the freeze; normal arbitration resumes the cycle after freeze falls.
- Read accepted at T, reset asserted at T+1 -> no readdatavalid; both waitrequests stay 1 until reset deasserts.

Source files
------------

// File: rtl/q_sys_descriptor_mem_pkg.sv
// Shared constants and types for the descriptor-memory arbiter slice.
package q_sys_descriptor_mem_pkg;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned MEM_DEPTH = 2048;

    // PRIORITY_MODE encodings
    localparam int unsigned PRIO_ROUND_ROBIN = 0;
    localparam int unsigned PRIO_FIXED_A     = 1;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/q_sys_rr_arbiter2.sv
// Two-input arbiter: round-robin on ties, or fixed priority to port A when mode is set.
module q_sys_rr_arbiter2
    import q_sys_descriptor_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       freeze,
    input  logic       mode,
    output logic [1:0] grant
);

    port_t last_grant_q;
    port_t last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (!reset && !freeze) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Tie: A wins under fixed priority, otherwise the port not served last.
                2'b11:   grant = (mode || last_grant_q == PORT_B) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = PORT_A;
        end else if (grant[1]) begin
            last_grant_d = PORT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/q_sys_descriptor_mem_arbiter.sv
// Shares the single-port descriptor memory between the CPU (A) and DMA (B) Avalon-MM masters.
module q_sys_descriptor_mem_arbiter
    import q_sys_descriptor_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = q_sys_descriptor_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W        = q_sys_descriptor_mem_pkg::DATA_W,
    parameter int unsigned BE_W          = q_sys_descriptor_mem_pkg::BE_W,
    parameter int unsigned PRIORITY_MODE = q_sys_descriptor_mem_pkg::PRIO_ROUND_ROBIN
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              sel_write;
    logic [ADDR_W-1:0] addr_d,  addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic [BE_W-1:0]   be_d,    be_q;
    logic              rd_pend_d, rd_pend_q;
    port_t             rd_port_d, rd_port_q;
    logic              rd_valid;

    assign req = {b_read | b_write, a_read | a_write};

    q_sys_rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .freeze (freeze),
        .mode   (PRIORITY_MODE == PRIO_FIXED_A),
        .grant  (grant)
    );

    // Idle cycles keep presenting the last address/data; reads always enable every lane.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        sel_write = 1'b0;
        if (grant[0]) begin
            addr_d    = a_address;
            wdata_d   = a_writedata;
            sel_write = a_write;
            be_d      = a_write ? a_byteenable : '1;
        end else if (grant[1]) begin
            addr_d    = b_address;
            wdata_d   = b_writedata;
            sel_write = b_write;
            be_d      = b_write ? b_byteenable : '1;
        end
    end

    always_comb begin
        rd_pend_d = (|grant) & ~sel_write;
        rd_port_d = grant[1] ? PORT_B : PORT_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT_A;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    assign mem_address    = addr_d;
    assign mem_writedata  = wdata_d;
    assign mem_byteenable = be_d;
    assign mem_write      = sel_write;
    assign mem_chipselect = |grant;
    assign mem_clken      = 1'b1;

    assign a_waitrequest = ~grant[0];
    assign b_waitrequest = ~grant[1];

    // A read in flight when reset rises is dropped rather than returned.
    assign rd_valid        = rd_pend_q & ~reset;
    assign a_readdatavalid = rd_valid & (rd_port_q == PORT_A);
    assign b_readdatavalid = rd_valid & (rd_port_q == PORT_B);
    assign a_readdata      = rd_valid ? mem_readdata : '0;
    assign b_readdata      = rd_valid ? mem_readdata : '0;

endmodule

// File: tb/tb_q_sys_descriptor_mem_arbiter.sv
// Self-checking bench: handshake vector table, directed corner sequences and randomized traffic vs. a reference model.
module tb_q_sys_descriptor_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, freeze;
    logic          a_read, a_write, b_read, b_write;
    logic [AW-1:0] a_address, b_address;
    logic [BW-1:0] a_byteenable, b_byteenable;
    logic [DW-1:0] a_writedata, b_writedata;
    logic          a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic [DW-1:0] a_readdata, b_readdata;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;

    // Second instance in fixed-priority mode, read-only traffic
    logic          p_a_read, p_b_read;
    logic [AW-1:0] p_a_address, p_b_address;
    logic          p_a_wait, p_b_wait, p_a_valid, p_b_valid;
    logic [DW-1:0] p_a_rdata, p_b_rdata;
    logic [AW-1:0] p_mem_address;
    logic [BW-1:0] p_mem_be;
    logic          p_mem_cs, p_mem_we, p_mem_clken;
    logic [DW-1:0] p_mem_wdata, p_mem_readdata;

    q_sys_descriptor_mem_arbiter #(.PRIORITY_MODE(0)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .a_read(a_read), .a_write(a_write), .a_address(a_address),
        .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_read(b_read), .b_write(b_write), .b_address(b_address),
        .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    q_sys_descriptor_mem_arbiter #(.PRIORITY_MODE(1)) dut_prio (
        .clk(clk), .reset(reset), .freeze(1'b0),
        .a_read(p_a_read), .a_write(1'b0), .a_address(p_a_address),
        .a_byteenable(4'h0), .a_writedata(32'h0),
        .a_waitrequest(p_a_wait), .a_readdata(p_a_rdata), .a_readdatavalid(p_a_valid),
        .b_read(p_b_read), .b_write(1'b0), .b_address(p_b_address),
        .b_byteenable(4'h0), .b_writedata(32'h0),
        .b_waitrequest(p_b_wait), .b_readdata(p_b_rdata), .b_readdatavalid(p_b_valid),
        .mem_address(p_mem_address), .mem_byteenable(p_mem_be), .mem_chipselect(p_mem_cs),
        .mem_write(p_mem_we), .mem_writedata(p_mem_wdata), .mem_clken(p_mem_clken),
        .mem_readdata(p_mem_readdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A0000 ^ (32'(i) * 32'h00012345);
    endfunction

    // Memory models: preloaded on the first edge (DUTs are in reset then), 1-cycle read latency
    logic [DW-1:0] mem0 [2048];
    logic [DW-1:0] mem1 [2048];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) begin
                mem0[i] <= init_word(i);
                mem1[i] <= init_word(i);
            end
            loaded <= 1'b1;
        end else begin
            if (mem_chipselect) begin
                if (mem_write) begin
                    for (int k = 0; k < BW; k++)
                        if (mem_byteenable[k]) mem0[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
                end else begin
                    mem_readdata <= mem0[mem_address];
                end
            end
            if (p_mem_cs && !p_mem_we) p_mem_readdata <= mem1[p_mem_address];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the round-robin instance: shadow memory, last winner, one in-flight read
    logic [31:0] shadow [2048];
    int          m_last = 1;
    bit          m_pend = 0;
    int          m_pend_port = 0;
    logic [31:0] m_pend_data = '0;

    task automatic model_grant(output bit ga, output bit gb);
        bit ra, rb;
        ra = a_read | a_write;
        rb = b_read | b_write;
        ga = 0;
        gb = 0;
        if (!reset && !freeze) begin
            if (ra && rb) begin
                if (m_last == 1) ga = 1; else gb = 1;
            end else begin
                ga = ra;
                gb = rb;
            end
        end
    endtask

    task automatic sample();
        bit ga, gb, eva, evb, wr;
        logic [AW-1:0] adr;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        @(negedge clk);
        model_grant(ga, gb);
        eva = !reset && m_pend && m_pend_port == 0;
        evb = !reset && m_pend && m_pend_port == 1;
        check("a_waitrequest", 32'(a_waitrequest), 32'(!ga));
        check("b_waitrequest", 32'(b_waitrequest), 32'(!gb));
        check("a_readdatavalid", 32'(a_readdatavalid), 32'(eva));
        check("b_readdatavalid", 32'(b_readdatavalid), 32'(evb));
        if (eva) check("a_readdata", a_readdata, m_pend_data);
        if (evb) check("b_readdata", b_readdata, m_pend_data);
        check("mem_chipselect", 32'(mem_chipselect), 32'(ga | gb));
        check("mem_clken", 32'(mem_clken), 32'd1);
        if (ga || gb) begin
            adr = ga ? a_address : b_address;
            wr  = ga ? a_write : b_write;
            be  = ga ? a_byteenable : b_byteenable;
            wd  = ga ? a_writedata : b_writedata;
            check("mem_address", 32'(mem_address), 32'(adr));
            check("mem_write", 32'(mem_write), 32'(wr));
            check("mem_byteenable", 32'(mem_byteenable), wr ? 32'(be) : 32'hF);
            if (wr) check("mem_writedata", mem_writedata, wd);
        end else begin
            check("mem_write_idle", 32'(mem_write), 32'd0);
        end
    endtask

    task automatic advance();
        bit ga, gb, wr;
        int adr;
        logic [31:0] w, wd;
        logic [3:0] be;
        model_grant(ga, gb);
        @(posedge clk);
        if (reset) begin
            m_pend = 0;
            m_last = 1;
        end else begin
            m_pend = 0;
            if (ga || gb) begin
                adr = ga ? int'(a_address) : int'(b_address);
                wr  = ga ? a_write : b_write;
                be  = ga ? a_byteenable : b_byteenable;
                wd  = ga ? a_writedata : b_writedata;
                if (wr) begin
                    w = shadow[adr];
                    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
                    shadow[adr] = w;
                end else begin
                    m_pend      = 1;
                    m_pend_port = ga ? 0 : 1;
                    m_pend_data = shadow[adr];
                end
                m_last = ga ? 0 : 1;
            end
        end
        #1;
    endtask

    task automatic set_a(input bit rd, input bit wr, input int adr, input logic [3:0] be, input logic [31:0] wd);
        a_read = rd; a_write = wr; a_address = AW'(adr); a_byteenable = be; a_writedata = wd;
    endtask

    task automatic set_b(input bit rd, input bit wr, input int adr, input logic [3:0] be, input logic [31:0] wd);
        b_read = rd; b_write = wr; b_address = AW'(adr); b_byteenable = be; b_writedata = wd;
    endtask

    typedef struct {
        bit rst, frz, ar, aw, br, bw;
        bit ewa, ewb, eva, evb;
    } vec_t;
    vec_t tbl [17];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bit acc_a, acc_b, prev_b, a_act, b_act;
        int wa, wb, nvalid, kind, prev_addr;

        tbl[0]  = '{1,0, 1,0,1,0, 1,1,0,0};
        tbl[1]  = '{0,0, 1,0,1,0, 0,1,0,0};
        tbl[2]  = '{0,0, 0,0,1,0, 1,0,1,0};
        tbl[3]  = '{0,0, 0,0,0,0, 1,1,0,1};
        tbl[4]  = '{0,0, 1,0,1,0, 0,1,0,0};
        tbl[5]  = '{0,0, 1,0,1,0, 1,0,1,0};
        tbl[6]  = '{0,0, 1,0,1,0, 0,1,0,1};
        tbl[7]  = '{0,1, 0,0,1,0, 1,1,1,0};
        tbl[8]  = '{0,1, 0,0,1,0, 1,1,0,0};
        tbl[9]  = '{0,0, 1,0,1,0, 1,0,0,0};
        tbl[10] = '{0,0, 1,0,0,1, 0,1,0,1};
        tbl[11] = '{0,0, 0,0,0,1, 1,0,1,0};
        tbl[12] = '{0,0, 0,0,0,0, 1,1,0,0};
        tbl[13] = '{0,0, 1,0,0,0, 0,1,0,0};
        tbl[14] = '{1,0, 1,0,0,0, 1,1,0,0};
        tbl[15] = '{0,0, 0,0,0,0, 1,1,0,0};
        tbl[16] = '{0,0, 1,0,1,0, 0,1,0,0};

        for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
        reset = 1; freeze = 0;
        set_a(0, 0, 0, 4'h0, 32'h0);
        set_b(0, 0, 0, 4'h0, 32'h0);
        p_a_read = 0; p_b_read = 0; p_a_address = '0; p_b_address = '0;
        for (int i = 0; i < 3; i++) begin
            sample();
            if (i > 0) check("reset_mem_address", 32'(mem_address), 32'd0);
            advance();
        end

        // Simultaneous reads after reset: A first, then B, each returning its preloaded word
        reset = 0;
        set_a(1, 0, 'h010, 4'h0, 32'h0);
        set_b(1, 0, 'h7FF, 4'h0, 32'h0);
        sample();
        check("seq1_a_accept", 32'(a_waitrequest), 32'd0);
        check("seq1_b_wait", 32'(b_waitrequest), 32'd1);
        advance();
        set_a(0, 0, 'h010, 4'h0, 32'h0);
        sample();
        check("seq1_b_accept", 32'(b_waitrequest), 32'd0);
        check("seq1_a_valid", 32'(a_readdatavalid), 32'd1);
        check("seq1_a_data", a_readdata, init_word('h010));
        advance();
        set_b(0, 0, 'h7FF, 4'h0, 32'h0);
        sample();
        check("seq1_b_valid", 32'(b_readdatavalid), 32'd1);
        check("seq1_b_data", b_readdata, init_word('h7FF));
        advance();

        // Partial-byte write followed by read-back
        set_a(0, 1, 'h123, 4'b0011, 32'hDEADBEEF);
        sample();
        check("seq2_wr_accept", 32'(a_waitrequest), 32'd0);
        advance();
        set_a(1, 0, 'h123, 4'h0, 32'h0);
        sample();
        advance();
        set_a(0, 0, 'h123, 4'h0, 32'h0);
        sample();
        w = init_word('h123);
        check("seq2_rd_valid", 32'(a_readdatavalid), 32'd1);
        check("seq2_rd_data", a_readdata, {w[31:16], 16'hBEEF});
        advance();

        // Handshake vector table
        set_a(0, 0, 'h020, 4'hF, 32'h0);
        set_b(0, 0, 'h7F0, 4'hF, 32'h11223344);
        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; freeze = tbl[i].frz;
            a_read = tbl[i].ar; a_write = tbl[i].aw;
            b_read = tbl[i].br; b_write = tbl[i].bw;
            sample();
            check($sformatf("tbl%0d_a_wait", i), 32'(a_waitrequest), 32'(tbl[i].ewa));
            check($sformatf("tbl%0d_b_wait", i), 32'(b_waitrequest), 32'(tbl[i].ewb));
            check($sformatf("tbl%0d_a_valid", i), 32'(a_readdatavalid), 32'(tbl[i].eva));
            check($sformatf("tbl%0d_b_valid", i), 32'(b_readdatavalid), 32'(tbl[i].evb));
            advance();
        end
        reset = 0; freeze = 0;
        set_a(0, 0, 0, 4'h0, 32'h0);
        set_b(0, 0, 0, 4'h0, 32'h0);
        sample();
        advance();

        // Continuous reads from both ports: strict alternation, gap-free returns
        set_a(1, 0, 'h100, 4'h0, 32'h0);
        set_b(1, 0, 'h200, 4'h0, 32'h0);
        wa = 0; wb = 0; nvalid = 0; prev_b = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            acc_a = !a_waitrequest;
            acc_b = !b_waitrequest;
            check("stream_one_accept", 32'(acc_a) + 32'(acc_b), 32'd1);
            if (c > 0) check("stream_alternate", 32'(acc_a), 32'(prev_b));
            wa = acc_a ? 0 : wa + 1;
            wb = acc_b ? 0 : wb + 1;
            check("stream_a_wait_max", 32'(wa <= 1), 32'd1);
            check("stream_b_wait_max", 32'(wb <= 1), 32'd1);
            nvalid += int'(a_readdatavalid) + int'(b_readdatavalid);
            prev_b = acc_b;
            advance();
            if (acc_a) a_address = AW'($urandom);
            if (acc_b) b_address = AW'($urandom);
        end
        set_a(0, 0, 0, 4'h0, 32'h0);
        set_b(0, 0, 0, 4'h0, 32'h0);
        sample();
        nvalid += int'(a_readdatavalid) + int'(b_readdatavalid);
        advance();
        check("stream_valid_count", 32'(nvalid), 32'd20);

        // Freeze right after a B read is accepted
        set_b(1, 0, 'h055, 4'h0, 32'h0);
        sample();
        check("frz_b_accept", 32'(b_waitrequest), 32'd0);
        advance();
        set_b(0, 0, 'h055, 4'h0, 32'h0);
        set_a(1, 0, 'h066, 4'h0, 32'h0);
        freeze = 1;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (c == 0) check("frz_b_valid", 32'(b_readdatavalid), 32'd1);
            check("frz_no_accept", 32'(a_waitrequest), 32'd1);
            advance();
        end
        freeze = 0;
        sample();
        check("frz_resume", 32'(a_waitrequest), 32'd0);
        advance();
        set_a(0, 0, 0, 4'h0, 32'h0);
        sample();
        advance();

        // Randomized traffic: masters hold each request until accepted
        a_act = 0; b_act = 0;
        for (int c = 0; c < 600; c++) begin
            freeze = ($urandom_range(0, 9) == 0);
            if (!a_act && $urandom_range(0, 2) != 0) begin
                a_act = 1;
                kind = $urandom_range(0, 3);
                set_a(kind != 2, kind >= 2, $urandom_range(0, 15), 4'($urandom), $urandom);
            end
            if (!b_act && $urandom_range(0, 2) != 0) begin
                b_act = 1;
                kind = $urandom_range(0, 3);
                set_b(kind != 2, kind >= 2, $urandom_range(0, 15), 4'($urandom), $urandom);
            end
            sample();
            acc_a = a_act && !a_waitrequest;
            acc_b = b_act && !b_waitrequest;
            advance();
            if (acc_a) begin a_act = 0; a_read = 0; a_write = 0; end
            if (acc_b) begin b_act = 0; b_read = 0; b_write = 0; end
        end
        freeze = 0;
        set_a(0, 0, 0, 4'h0, 32'h0);
        set_b(0, 0, 0, 4'h0, 32'h0);
        sample();
        advance();

        // Fixed-priority instance: A starves B until it drops its request
        p_a_read = 1; p_b_read = 1; p_a_address = AW'(5); p_b_address = AW'(6);
        prev_addr = 5;
        for (int c = 0; c < 10; c++) begin
            sample();
            check("prio_a_accept", 32'(p_a_wait), 32'd0);
            check("prio_b_wait", 32'(p_b_wait), 32'd1);
            if (c > 0) begin
                check("prio_a_valid", 32'(p_a_valid), 32'd1);
                check("prio_a_data", p_a_rdata, init_word(prev_addr));
            end
            prev_addr = int'(p_a_address);
            advance();
            p_a_address = AW'(c + 7);
        end
        p_a_read = 0;
        sample();
        check("prio_b_accept", 32'(p_b_wait), 32'd0);
        advance();
        p_b_read = 0;
        sample();
        check("prio_b_valid", 32'(p_b_valid), 32'd1);
        check("prio_b_data", p_b_rdata, init_word(6));
        advance();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
